// File: rtl/shift_exec_stage.sv
// Two-stage shift execution unit (SLL/SRL/SRA) with valid/ready on both sides.
// Optional rotate-right for op 11 is enabled by defining SHIFT_EXEC_ROTATE_EN.
module shift_exec_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic            in_use_imm,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_imm,
    input  logic [REGW-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [REGW-1:0] out_rd,
    output logic            out_zero,
    output logic            out_illegal
);

    localparam int unsigned SHW = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    logic            s1_valid;
    logic [1:0]      s1_op;
    logic [SHW-1:0]  s1_shamt;
    logic [XLEN-1:0] s1_rs1;
    logic [REGW-1:0] s1_rd;

    logic            s2_adv;
    logic            s1_adv;
    logic            in_fire;
    logic [SHW-1:0]  in_shamt;
    logic [XLEN-1:0] s1_shifted;
    logic            s1_illegal;
    logic            rs2_hi_unused;

    // Only rs2[4:0] carries a shift amount; the upper bits are architecturally ignored.
    assign rs2_hi_unused = ^in_rs2[XLEN-1:SHW];

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && !flush;
    assign in_fire  = in_valid && in_ready;
    assign in_shamt = in_use_imm ? in_imm : in_rs2[SHW-1:0];

`ifdef SHIFT_EXEC_ROTATE_EN
    logic [XLEN-1:0] s1_rot;

    // Shifting the doubled word right leaves the rotation in the low half.
    assign s1_rot = XLEN'({s1_rs1, s1_rs1} >> s1_shamt);
`endif

    // Shift datapath between S1 and S2
    always_comb begin
        s1_shifted = s1_rs1;
        s1_illegal = 1'b0;
        case (s1_op)
            OP_SLL:  s1_shifted = s1_rs1 << s1_shamt;
            OP_SRL:  s1_shifted = s1_rs1 >> s1_shamt;
            OP_SRA:  s1_shifted = XLEN'($signed(s1_rs1) >>> s1_shamt);
            default: begin
`ifdef SHIFT_EXEC_ROTATE_EN
                s1_shifted = s1_rot;
`else
                s1_shifted = s1_rs1;
                s1_illegal = 1'b1;
`endif
            end
        endcase
    end

    // S1: operand capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= 2'b00;
            s1_shamt <= '0;
            s1_rs1   <= '0;
            s1_rd    <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (in_fire) begin
                s1_op    <= in_op;
                s1_shamt <= in_shamt;
                s1_rs1   <= in_rs1;
                s1_rd    <= in_rd;
            end
        end
    end

    // S2: result register driving writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_rd      <= '0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (s2_adv) begin
                out_valid <= s1_valid;
            end
            if (s2_adv && s1_valid) begin
                out_result  <= s1_shifted;
                out_rd      <= s1_rd;
                out_zero    <= (s1_shifted == '0);
                out_illegal <= s1_illegal;
            end
        end
    end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed self-checking bench for shift_exec_stage; honours SHIFT_EXEC_ROTATE_EN.
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic        in_use_imm = 1'b0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [4:0]  in_imm = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_zero;
    logic        out_illegal;

    int n_assert = 0;
    int n_fail   = 0;

    // Back-to-back vectors with hand-computed results
    logic [1:0]  bb_op  [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 2'b10};
    logic [31:0] bb_rs1 [8] = '{32'h000000F0, 32'hF0000000, 32'h000000F0, 32'hF0000000,
                                32'h12345678, 32'h12345678, 32'h7FFFFFFF, 32'h80000000};
    logic [4:0]  bb_imm [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd31, 5'd31};
    logic [31:0] bb_exp [8] = '{32'h000000F0, 32'h78000000, 32'h000003C0, 32'hFE000000,
                                32'h23456780, 32'h00123456, 32'h00000000, 32'hFFFFFFFF};

    shift_exec_stage #(.XLEN(32), .REGW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_use_imm (in_use_imm),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_zero   (out_zero),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic use_imm,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] imm, input logic [4:0] rd);
        in_valid   = v;
        in_op      = op;
        in_use_imm = use_imm;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_imm     = imm;
        in_rd      = rd;
    endtask

    // One instruction through an empty pipe with out_ready=1: valid after the second edge
    task automatic run_one(input string tag, input logic [1:0] op, input logic use_imm,
                           input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] imm,
                           input logic [4:0] rd, input logic [31:0] exp_res,
                           input logic exp_zero, input logic exp_ill);
        @(negedge clk);
        drive(1'b1, op, use_imm, rs1, rs2, imm, rd);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".valid_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".result"}, out_result, exp_res);
        check({tag, ".rd"}, 32'(out_rd), 32'(rd));
        check({tag, ".zero"}, 32'(out_zero), 32'(exp_zero));
        check({tag, ".illegal"}, 32'(out_illegal), 32'(exp_ill));
    endtask

    initial begin
        int idx;

        // Reset values
        #1;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.result", out_result, 32'd0);
        check("rst.rd", 32'(out_rd), 32'd0);
        check("rst.zero", 32'(out_zero), 32'd0);
        check("rst.illegal", 32'(out_illegal), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_one("sra_imm", 2'b10, 1'b1, 32'h80000010, 32'h0, 5'd4, 5'd7, 32'hF8000001, 1'b0, 1'b0);
        run_one("sll_reg", 2'b00, 1'b0, 32'h00000001, 32'hFFFFFFE3, 5'd0, 5'd3, 32'h00000008, 1'b0, 1'b0);
        run_one("srl_reg31", 2'b01, 1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd0, 5'd9, 32'h00000001, 1'b0, 1'b0);
        run_one("sll_zero", 2'b00, 1'b1, 32'h80000000, 32'h0, 5'd1, 5'd2, 32'h00000000, 1'b1, 1'b0);
        run_one("sra_sh0", 2'b10, 1'b1, 32'h8000ABCD, 32'h0, 5'd0, 5'd31, 32'h8000ABCD, 1'b0, 1'b0);
`ifdef SHIFT_EXEC_ROTATE_EN
        run_one("ror1", 2'b11, 1'b1, 32'h00000001, 32'h0, 5'd1, 5'd4, 32'h80000000, 1'b0, 1'b0);
        run_one("ror0", 2'b11, 1'b0, 32'h12345678, 32'hFFFFFFE0, 5'd0, 5'd5, 32'h12345678, 1'b0, 1'b0);
`else
        run_one("op11", 2'b11, 1'b1, 32'h00000001, 32'h0, 5'd1, 5'd4, 32'h00000001, 1'b0, 1'b1);
`endif

        // Back-to-back: item k presented in cycle k is seen at the output in cycle k+2
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 8) drive(1'b1, bb_op[c], 1'b1, bb_rs1[c], 32'h0, bb_imm[c], 5'(c + 1));
            else       in_valid = 1'b0;
            check($sformatf("b2b.in_ready%0d", c), 32'(in_ready), 32'd1);
            if (c >= 2) begin
                check($sformatf("b2b.valid%0d", c), 32'(out_valid), 32'd1);
                check($sformatf("b2b.result%0d", c - 2), out_result, bb_exp[c-2]);
                check($sformatf("b2b.rd%0d", c - 2), 32'(out_rd), 32'(c - 1));
            end else begin
                check($sformatf("b2b.valid%0d", c), 32'(out_valid), 32'd0);
            end
        end
        @(negedge clk);
        check("b2b.drained", 32'(out_valid), 32'd0);

        // Backpressure: two slots fill, then in_ready drops and the output holds
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(1'b1, 2'b01, 1'b1, 32'hA5A5A5A5, 32'h0, 5'(idx), 5'(10 + idx));
            check($sformatf("bp.in_ready%0d", c), 32'(in_ready), (c < 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                check($sformatf("bp.valid%0d", c), 32'(out_valid), 32'd1);
                check($sformatf("bp.hold%0d", c), out_result, 32'hA5A5A5A5);
                check($sformatf("bp.hold_rd%0d", c), 32'(out_rd), 32'd10);
            end else begin
                check($sformatf("bp.valid%0d", c), 32'(out_valid), 32'd0);
            end
            if (c < 2) idx++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        check("bp.rel0.valid", 32'(out_valid), 32'd1);
        check("bp.rel0.result", out_result, 32'hA5A5A5A5);
        check("bp.rel0.rd", 32'(out_rd), 32'd10);
        @(negedge clk);
        check("bp.rel1.valid", 32'(out_valid), 32'd1);
        check("bp.rel1.result", out_result, 32'h52D2D2D2);
        check("bp.rel1.rd", 32'(out_rd), 32'd11);
        @(negedge clk);
        check("bp.rel.empty", 32'(out_valid), 32'd0);

        // Flush with both stages full and a new instruction offered
        out_ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b1, 32'h1, 32'h0, 5'd1, 5'd20);
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b1, 32'h1, 32'h0, 5'd2, 5'd21);
        @(negedge clk);
        check("fl.full", 32'(out_valid), 32'd1);
        drive(1'b1, 2'b00, 1'b1, 32'h1, 32'h0, 5'd3, 5'd22);
        flush = 1'b1;
        #1;
        check("fl.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("fl.valid0", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("fl.valid1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("fl.valid2", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a stream
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b1, 32'h3, 32'h0, 5'd4, 5'd25);
        @(negedge clk);
        drive(1'b1, 2'b01, 1'b1, 32'h300, 32'h0, 5'd4, 5'd26);
        @(negedge clk);
        check("ar.pre.valid", 32'(out_valid), 32'd1);
        check("ar.pre.result", out_result, 32'h30);
        #2;
        rst = 1'b1;
        #1;
        check("ar.valid", 32'(out_valid), 32'd0);
        check("ar.result", out_result, 32'd0);
        check("ar.rd", 32'(out_rd), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("ar.post0", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("ar.post1", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
